// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned DefCntW = 16;
  localparam int unsigned DefDiv  = 50;

  typedef logic [DefCntW-1:0] div_t;

  // Channel-select width: clog2 of the channel count, never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag, clkout and tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned DEF_DIV = DefDiv
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             align,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
  output logic             pend,
  output logic             clkout,
  output logic             tick
);

  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DivRst = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d, next_div;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
  logic             stopped, term;

  assign stopped = (div_q == '0);
  assign term    = en && !stopped && (cnt_q == div_q - One);

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    next_div = pend_q ? shadow_q : div_q;
    if (align) begin
      // Phase reset: pending divisor lands now; a coincident write stays pending.
      cnt_d  = '0;
      clk_d  = 1'b0;
      div_d  = next_div;
      pend_d = 1'b0;
      if (wr) begin
        shadow_d = val;
        pend_d   = 1'b1;
      end
    end else if (stopped || term) begin
      // Apply point; a write landing here bypasses the shadow.
      if (wr) next_div = val;
      div_d  = next_div;
      pend_d = 1'b0;
      cnt_d  = '0;
      if (stopped || next_div == '0) begin
        clk_d = 1'b0;
      end else begin
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
      end
    end else begin
      if (en) cnt_d = cnt_q + One;
      if (wr) begin
        shadow_d = val;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      div_q    <= DivRst;
      shadow_q <= DivRst;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign pend   = pend_q;
  assign clkout = clk_q;
  assign tick   = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider. Define CLKDIV_ALIGN_EN to add the
// align input that phase-resets every channel.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned DEF_DIV = DefDiv,
  parameter int unsigned SEL_W   = sel_width(NUM_CH)
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              en,
`ifdef CLKDIV_ALIGN_EN
  input  logic              align,
`endif
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] div_pend,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] tick
);

  logic              align_int;
  logic [NUM_CH-1:0] wr_vec;

`ifdef CLKDIV_ALIGN_EN
  assign align_int = align;
`else
  assign align_int = 1'b0;
`endif

  // Out-of-range selects match no channel and are dropped.
  always_comb begin
    wr_vec = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_vec[i] = div_wr && (32'(div_sel) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clkdiv_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clkin  (clkin),
      .reset  (reset),
      .en     (en),
      .align  (align_int),
      .wr     (wr_vec[g]),
      .val    (div_val),
      .pend   (div_pend[g]),
      .clkout (clkout[g]),
      .tick   (tick[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: directed scenarios plus randomized traffic
// compared every cycle against a countdown-based reference model.
module tb_clkdiv_multi;
  import clkdiv_pkg::*;

  localparam int unsigned NumCh = 3;
  localparam int unsigned CntW  = 16;
  localparam int unsigned DefD  = 50;
  localparam int unsigned SelW  = sel_width(NumCh);

  logic             clkin = 1'b0;
  logic             reset;
  logic             en;
  logic             align;
  logic             div_wr;
  logic [SelW-1:0]  div_sel;
  logic [CntW-1:0]  div_val;
  logic [NumCh-1:0] div_pend, clkout, tick;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: half-period length, cycles remaining in it, output level.
  int unsigned m_div[NumCh], m_shadow[NumCh], m_rem[NumCh];
  bit          m_pend[NumCh], m_level[NumCh], m_tick[NumCh];

  always #5 clkin = ~clkin;

  clkdiv_multi #(
    .NUM_CH  (NumCh),
    .CNT_W   (CntW),
    .DEF_DIV (DefD)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .en       (en),
`ifdef CLKDIV_ALIGN_EN
    .align    (align),
`endif
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_val  (div_val),
    .div_pend (div_pend),
    .clkout   (clkout),
    .tick     (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NumCh; c++) begin
      m_div[c] = DefD; m_shadow[c] = DefD; m_rem[c] = DefD;
      m_pend[c] = 0; m_level[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NumCh; c++) begin
      bit          wr;
      int unsigned nd;
      wr = div_wr && (32'(div_sel) == c);
      m_tick[c] = 0;
      if (align) begin
        if (m_pend[c]) m_div[c] = m_shadow[c];
        m_pend[c] = 0; m_level[c] = 0; m_rem[c] = m_div[c];
        if (wr) begin m_shadow[c] = div_val; m_pend[c] = 1; end
      end else if (m_div[c] == 0) begin
        if (wr) m_div[c] = div_val;
        else if (m_pend[c]) m_div[c] = m_shadow[c];
        m_pend[c] = 0; m_level[c] = 0; m_rem[c] = m_div[c];
      end else if (en && m_rem[c] == 1) begin
        nd = wr ? int'(div_val) : (m_pend[c] ? m_shadow[c] : m_div[c]);
        m_div[c] = nd; m_pend[c] = 0; m_rem[c] = nd;
        if (nd == 0) m_level[c] = 0;
        else begin m_tick[c] = !m_level[c]; m_level[c] = !m_level[c]; end
      end else begin
        if (en) m_rem[c]--;
        if (wr) begin m_shadow[c] = div_val; m_pend[c] = 1; end
      end
    end
  endtask

  task automatic check_all();
    logic [NumCh-1:0] ec, et, ep;
    for (int c = 0; c < NumCh; c++) begin
      ec[c] = m_level[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    check_eq("clkout", 32'(clkout), 32'(ec));
    check_eq("tick", 32'(tick), 32'(et));
    check_eq("div_pend", 32'(div_pend), 32'(ep));
  endtask

  task automatic step();
    @(posedge clkin);
    if (!reset) model_reset(); else model_step();
    @(negedge clkin);
    check_all();
  endtask

  task automatic steps_to_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin step(); n++; end while (!tick[ch] && n < limit);
  endtask

  int n, first_tick, tick_cnt, high_cnt, guard, rise0, rise1;

  initial begin
    reset = 1'b0; en = 1'b1; align = 1'b0;
    div_wr = 1'b0; div_sel = '0; div_val = '0;
    model_reset();
    step(); step();
    reset = 1'b1;
    check_eq("rst_clkout", 32'(clkout), 0);
    check_eq("rst_tick", 32'(tick), 0);
    check_eq("rst_pend", 32'(div_pend), 0);

    // Default divisor: ticks on cycles 50, 150, 250 only.
    first_tick = -1; tick_cnt = 0; high_cnt = 0;
    for (int k = 1; k <= 251; k++) begin
      step();
      if (tick[0]) begin tick_cnt++; if (first_tick < 0) first_tick = k; end
      if (clkout[0]) high_cnt++;
    end
    check_eq("def_first_tick", first_tick, 50);
    check_eq("def_tick_count", tick_cnt, 3);
    check_eq("def_high_cycles", high_cnt, 102);

    // ch1 gets D=3 mid-count at cnt=10; pend holds until its terminal edge.
    guard = 0;
    while (m_rem[1] != 40 && guard < 200) begin step(); guard++; end
    check_eq("wait_ch1_cnt10", guard < 200, 1);
    div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd3;
    step(); n = 1;
    div_wr = 1'b0;
    check_eq("ch1_pend_set", div_pend[1], 1);
    while (div_pend[1] && n < 100) begin step(); n++; end
    check_eq("ch1_pend_clear_steps", n, 40);
    steps_to_tick(1, 20, n);
    steps_to_tick(1, 20, n);
    check_eq("ch1_period", n, 6);

    // ch2: stop with D=0, then restart with D=4 via the stopped bypass.
    div_wr = 1'b1; div_sel = 2'd2; div_val = 16'd0;
    step(); n = 1;
    div_wr = 1'b0;
    while (div_pend[2] && n < 100) begin step(); n++; end
    check_eq("ch2_stopped_low", clkout[2], 0);
    div_wr = 1'b1; div_val = 16'd4;
    step(); n = 1;
    div_wr = 1'b0;
    check_eq("ch2_pend_after_bypass", div_pend[2], 0);
    while (!clkout[2] && n < 20) begin step(); n++; end
    check_eq("ch2_first_high", n, 5);

    // ch0 written in its terminal cycle, then an out-of-range write.
    guard = 0;
    while (m_rem[0] != 1 && guard < 200) begin step(); guard++; end
    check_eq("wait_ch0_term", guard < 200, 1);
    div_wr = 1'b1; div_sel = 2'd0; div_val = 16'd7;
    step();
    check_eq("ch0_term_no_pend", div_pend[0], 0);
    div_sel = 2'd3; div_val = 16'd1;
    step();
    div_wr = 1'b0;
    check_eq("oob_no_pend", 32'(div_pend), 0);
    steps_to_tick(0, 40, n);
    steps_to_tick(0, 40, n);
    check_eq("ch0_period", n, 14);

    // Freeze mid-high phase for 20 cycles; the high phase then finishes normally.
    guard = 0;
    while (!(m_level[0] && m_rem[0] == 4) && guard < 100) begin step(); guard++; end
    check_eq("wait_ch0_midhigh", guard < 100, 1);
    en = 1'b0; tick_cnt = 0;
    for (int k = 0; k < 20; k++) begin step(); if (tick != '0) tick_cnt++; end
    check_eq("frozen_ticks", tick_cnt, 0);
    check_eq("frozen_ch0_high", clkout[0], 1);
    en = 1'b1; n = 0;
    while (clkout[0] && n < 20) begin step(); n++; end
    check_eq("resume_high_remaining", n, 4);

    // Asynchronous reset mid-phase.
    guard = 0;
    while (!m_level[0] && guard < 100) begin step(); guard++; end
    #2 reset = 1'b0;
    #1 check_eq("async_rst_clkout", 32'(clkout), 0);
    check_eq("async_rst_pend", 32'(div_pend), 0);
    step();
    reset = 1'b1;

`ifdef CLKDIV_ALIGN_EN
    div_wr = 1'b1; div_sel = 2'd0; div_val = 16'd2; step();
    div_sel = 2'd1; div_val = 16'd5; step();
    div_wr = 1'b0; n = 0;
    while (div_pend[1:0] != '0 && n < 150) begin step(); n++; end
    for (int k = 0; k < 13; k++) step();
    align = 1'b1; step(); align = 1'b0;
    check_eq("align_low", 32'(clkout[1:0]), 0);
    rise0 = -1; rise1 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (clkout[0] && rise0 < 0) rise0 = k;
      if (clkout[1] && rise1 < 0) rise1 = k;
    end
    check_eq("align_ch0_rise", rise0, 2);
    check_eq("align_ch1_rise", rise1, 5);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      en      = ($urandom_range(0, 9) != 0);
      div_wr  = ($urandom_range(0, 5) == 0);
      div_sel = SelW'($urandom_range(0, 3));
      div_val = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(9, 30))
                                            : 16'($urandom_range(0, 8));
`ifdef CLKDIV_ALIGN_EN
      align   = ($urandom_range(0, 63) == 0);
`endif
      step();
    end
    div_wr = 1'b0; align = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Multi-channel, runtime-programmable successor to the single fixed slow-clock divider.
- Each of NUM_CH channels divides clkin by 2*D and produces a registered 50%-duty clkout plus a one-cycle tick at each clkout rising edge.
- Divisors are written through a simple write port and take effect glitch-free at the channel's next half-period boundary.
- Sits between the board clock and slow peripherals (LED blink, debouncers, display scan).

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 16, divisor/counter width in bits.
- DEF_DIV, 50, reset divisor for every channel; must be < 2^CNT_W.
- SEL_W, $clog2(NUM_CH) (min 1), width of channel select.

Ports:
- clkin  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global run; low freezes all counters, clkout and pending state; tick forced 0.
- div_wr  in  1  one-cycle divisor write strobe.
- div_sel  in  SEL_W  target channel for div_wr.
- div_val  in  CNT_W  new divisor D.
- div_pend  out  NUM_CH  per-channel flag: written divisor not yet applied.
- clkout  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle pulse coincident with clkout 0->1.

Behaviour:
- Reset (reset=0, async):
  - cnt=0, active divisor=DEF_DIV, shadow=DEF_DIV.
  - clkout=0, tick=0, div_pend=0.
- Per-channel count, when en=1 and active D>0:
  - cnt increments each cycle.
  - When cnt==D-1: next edge sets cnt<=0 and clkout<=~clkout.
  - Result: clkout period 2*D cycles, exactly D high and D low.
- tick <= (cnt==D-1) & ~clkout & en. It is high in the same cycle clkout first reads 1; otherwise 0.
- D=0: channel stopped; cnt=0, clkout held 0, tick 0.
- Writes:
  - div_wr with div_sel>=NUM_CH is ignored.
  - Otherwise div_val goes to the channel shadow and div_pend[sel] is set at the next edge.
  - A second write while pending overwrites the shadow (last write wins).
- Apply point (edge where the pending divisor becomes active):
  - If active D>0: the terminal edge (cnt==D-1, en=1). Active D <= shadow, cnt <= 0, clkout toggles as normal, div_pend clears.
  - If active D==0: the next edge regardless of en. Active D <= shadow, cnt <= 0, clkout stays 0, div_pend clears.
- Write in the channel's terminal cycle (or while active D==0):
  - div_val bypasses the shadow and is applied directly at that edge.
  - div_pend stays 0.
- Latency:
  - From a running channel, a new D starts at the next half-period boundary.
  - From stopped (D==0), a write in cycle t gives cnt=0 in cycle t+1; clkout first reads 1 in cycle t+1+D.
- en=0:
  - cnt, clkout, div_pend and shadow are held. Writes are still accepted into the shadow.
  - Pending apply waits for a terminal edge with en=1, except when active D==0.
- Wrap-around: cnt never exceeds D-1; D=2^CNT_W-1 is the maximum (period 2*(2^CNT_W-1)).
- Reset mid-operation: immediate return to reset values on all channels; pending writes are lost.

Optional Feature:
- Macro: CLKDIV_ALIGN_EN.
- With it defined:
  - Extra input port align (1 bit).
  - align=1 at an edge forces every channel to cnt<=0 and clkout<=0, with tick 0 that cycle.
  - Any pending shadows are applied and div_pend clears.
  - Channels become phase-aligned.
  - align has priority over terminal-count and write-bypass; a simultaneous div_wr goes to the shadow and sets pend.
- Without it: no align port; channel phases depend only on write history.

Decomposition:
- Package clkdiv_pkg holds:
  - CNT_W default and DEF_DIV default.
  - A localparam function for SEL_W (clog2, min 1).
  - Typedef div_t (logic [CNT_W-1:0]).
- Natural sub-module: clkdiv_chan (one counter, shadow, pend, clkout, tick), instantiated NUM_CH times via generate.
- Top decodes div_wr/div_sel into per-channel write strobes.

Test Plan:
- Reset, DEF_DIV=50, en=1 -> all clkout 0 for 50 cycles, then high for 50; tick 1 in cycles 50,150,250 only; div_pend=0.
- Write D=3 to ch1 mid-count at cnt=10 -> div_pend[1]=1 until ch1 terminal edge at cnt=49; then ch1 period 6 cycles (3 high/3 low); other channels unchanged.
- Write D=0 to ch2, then D=4 to ch2 -> ch2 stops low at its next boundary; after second write, ch2 clkout first high 5 cycles after the write cycle; pend clears in 1 cycle.
- Write D=7 to ch0 exactly in its terminal cycle, then div_sel=NUM_CH write -> D=7 applied that edge with pend never set; out-of-range write changes nothing.
- en=0 for 20 cycles mid-high phase -> clkout/cnt frozen, tick 0; resume continues the count with no extra or short phase; reset=0 asynchronously mid-phase -> clkout 0 immediately.
- (CLKDIV_ALIGN_EN) ch0 D=2, ch1 D=5 free-running, pulse align -> both cnt=0 and clkout=0 the next cycle; ch0 rises 2 cycles later, ch1 5 cycles later.
